// File: rtl/riscv_v_pkg.sv
// Shared RISC-V vector pipeline definitions.
//   RISCV_V_RF_ADDR_WIDTH    : vector register-file address width
//   riscv_v_elastic_state_e  : occupancy state of riscv_v_elastic_stage
package riscv_v_pkg;

  localparam int unsigned RISCV_V_RF_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    RISCV_V_ELASTIC_EMPTY = 2'b00,
    RISCV_V_ELASTIC_BUSY  = 2'b01,
    RISCV_V_ELASTIC_FULL  = 2'b10
  } riscv_v_elastic_state_e;

endpackage

// File: rtl/riscv_v_elastic_stage.sv
// Elastic pipeline stage with valid/ready handshake and a 2-entry skid buffer.
// Full throughput (1 transfer/cycle) and 1-cycle latency. in_ready and out_valid
// decode from the state register only, so there is no combinational path from
// out_ready to in_ready or from in_* to out_*.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   flush         synchronous flush, empties the stage and cancels this cycle's transfers
//   in_valid/in_ready/in_data     upstream handshake and payload
//   out_valid/out_ready/out_data  downstream handshake and payload (out_data = main_q)
//   occupancy     entries held, 0..2
//   stall_cnt     saturating count of cycles with out_valid & !out_ready; present
//                 only when RISCV_V_ELASTIC_STAGE_STALL_CNT_EN is defined
module riscv_v_elastic_stage
  import riscv_v_pkg::*;
#(
  parameter int unsigned       DATA_W  = RISCV_V_RF_ADDR_WIDTH,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef RISCV_V_ELASTIC_STAGE_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  riscv_v_elastic_state_e state_q, state_d;
  logic [DATA_W-1:0]      main_q, main_d;
  logic [DATA_W-1:0]      skid_q, skid_d;
  logic                   in_fire, out_fire;

  assign in_ready  = (state_q != RISCV_V_ELASTIC_FULL);
  assign out_valid = (state_q != RISCV_V_ELASTIC_EMPTY);
  assign out_data  = main_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    case (state_q)
      RISCV_V_ELASTIC_BUSY: occupancy = 2'd1;
      RISCV_V_ELASTIC_FULL: occupancy = 2'd2;
      default:              occupancy = 2'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = RISCV_V_ELASTIC_EMPTY;
      main_d  = RST_VAL;
      skid_d  = RST_VAL;
    end else begin
      case (state_q)
        RISCV_V_ELASTIC_EMPTY: begin
          if (in_fire) begin
            state_d = RISCV_V_ELASTIC_BUSY;
            main_d  = in_data;
          end
        end
        RISCV_V_ELASTIC_BUSY: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            // Downstream stalled: park the new beat behind the one on display.
            state_d = RISCV_V_ELASTIC_FULL;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = RISCV_V_ELASTIC_EMPTY;
          end
        end
        RISCV_V_ELASTIC_FULL: begin
          // in_ready is low here, so only a drain can happen.
          if (out_fire) begin
            state_d = RISCV_V_ELASTIC_BUSY;
            main_d  = skid_q;
          end
        end
        default: state_d = RISCV_V_ELASTIC_EMPTY;  // illegal encoding recovers
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RISCV_V_ELASTIC_EMPTY;
      main_q  <= RST_VAL;
      skid_q  <= RST_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef RISCV_V_ELASTIC_STAGE_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Only rst clears the counter; flush deliberately leaves it alone.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

`ifndef SYNTHESIS
  state_legal_a: assert property (@(posedge clk) disable iff (rst)
    (state_q inside {RISCV_V_ELASTIC_EMPTY, RISCV_V_ELASTIC_BUSY, RISCV_V_ELASTIC_FULL}))
    else $error("riscv_v_elastic_stage: illegal state encoding %b", state_q);
`endif

endmodule

// File: tb/tb_riscv_v_elastic_stage.sv
// Directed and scoreboard-checked bench for riscv_v_elastic_stage.
// Covers the stall counter only when RISCV_V_ELASTIC_STAGE_STALL_CNT_EN is defined.
module tb_riscv_v_elastic_stage;
  import riscv_v_pkg::*;

  localparam int unsigned DW = RISCV_V_RF_ADDR_WIDTH;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
`ifdef RISCV_V_ELASTIC_STAGE_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  riscv_v_elastic_stage #(
    .DATA_W (DW),
    .RST_VAL('0)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .occupancy(occupancy)
`ifdef RISCV_V_ELASTIC_STAGE_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] sb_q[$];
  logic          exp_in_fire, exp_out_fire;
  logic          prev_stall;
  logic [DW-1:0] prev_data;

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #1;
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_occupancy", {30'd0, occupancy}, 32'd0);
    check_eq("rst_out_data", {27'd0, out_data}, 32'd0);
    step();
    step();
    rst = 1'b0;
    step();

    // 1. Reset mid-stream from FULL holding 03, 04.
    in_valid = 1'b1;
    in_data  = 5'h03;
    step();
    in_data = 5'h04;
    step();
    in_valid = 1'b0;
    check_eq("t1_full_occ", {30'd0, occupancy}, 32'd2);
    check_eq("t1_full_in_ready", {31'd0, in_ready}, 32'd0);
    check_eq("t1_full_data", {27'd0, out_data}, 32'h03);
    rst = 1'b1;
    #1;
    check_eq("t1_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("t1_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("t1_rst_occ", {30'd0, occupancy}, 32'd0);
    check_eq("t1_rst_out_data", {27'd0, out_data}, 32'd0);
    step();
    rst = 1'b0;
    step();

    // 2. Back-to-back streaming 01..1F, one beat out per cycle, no bubbles.
    out_ready = 1'b1;
    for (int i = 1; i < 32; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(i);
      check_eq("t2_in_ready", {31'd0, in_ready}, 32'd1);
      step();
      check_eq("t2_out_valid", {31'd0, out_valid}, 32'd1);
      check_eq("t2_out_data", {27'd0, out_data}, 32'(i));
    end
    in_valid = 1'b0;
    step();
    check_eq("t2_drained", {31'd0, out_valid}, 32'd0);

    // 3. Backpressure: 0A, 0B accepted, 0C held upstream, then drained in order.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 5'h0A;
    step();
    check_eq("t3_ready_after_1", {31'd0, in_ready}, 32'd1);
    in_data = 5'h0B;
    step();
    check_eq("t3_ready_after_2", {31'd0, in_ready}, 32'd0);
    check_eq("t3_occ_full", {30'd0, occupancy}, 32'd2);
    in_data = 5'h0C;
    step();
    check_eq("t3_occ_held", {30'd0, occupancy}, 32'd2);
    check_eq("t3_data_0a", {27'd0, out_data}, 32'h0A);
    out_ready = 1'b1;
    step();
    check_eq("t3_data_0b", {27'd0, out_data}, 32'h0B);
    check_eq("t3_occ_busy", {30'd0, occupancy}, 32'd1);
    check_eq("t3_ready_back", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    check_eq("t3_data_0c", {27'd0, out_data}, 32'h0C);
    check_eq("t3_valid_0c", {31'd0, out_valid}, 32'd1);
    step();
    check_eq("t3_empty", {31'd0, out_valid}, 32'd0);

    // 4. Flush from BUSY(07) with coincident in_fire and out_fire.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 5'h07;
    step();
    check_eq("t4_busy_data", {27'd0, out_data}, 32'h07);
    flush     = 1'b1;
    in_data   = 5'h08;
    out_ready = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_eq("t4_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("t4_occ", {30'd0, occupancy}, 32'd0);
    check_eq("t4_out_data", {27'd0, out_data}, 32'd0);
    step();
    check_eq("t4_no_08", {31'd0, out_valid}, 32'd0);

    // 5. Random traffic against a queue model.
    prev_stall = 1'b0;
    prev_data  = '0;
    for (int c = 0; c < 10000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = DW'($urandom_range(0, 31));
      out_ready = 1'($urandom_range(0, 1));
      #1;
      check_eq("t5_in_ready", {31'd0, in_ready}, {31'd0, sb_q.size() < 2});
      check_eq("t5_out_valid", {31'd0, out_valid}, {31'd0, sb_q.size() > 0});
      check_eq("t5_occ", {30'd0, occupancy}, 32'(sb_q.size()));
      if (sb_q.size() > 0) check_eq("t5_order", {27'd0, out_data}, {27'd0, sb_q[0]});
      if (prev_stall) check_eq("t5_stable", {27'd0, out_data}, {27'd0, prev_data});
      exp_in_fire  = in_valid && (sb_q.size() < 2);
      exp_out_fire = out_ready && (sb_q.size() > 0);
      prev_stall   = (sb_q.size() > 0) && !out_ready;
      prev_data    = (sb_q.size() > 0) ? sb_q[0] : '0;
      step();
      if (exp_out_fire) void'(sb_q.pop_front());
      if (exp_in_fire) sb_q.push_back(in_data);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    check_eq("t5_final_empty", {31'd0, out_valid}, 32'd0);

`ifdef RISCV_V_ELASTIC_STAGE_STALL_CNT_EN
    // 6. Stall counter: saturate, survive flush, clear on rst.
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("t6_cnt_reset", 32'(stall_cnt), 32'd0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 5'h11;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    check_eq("t6_cnt_3", 32'(stall_cnt), 32'd3);
    for (int c = 0; c < 70000; c++) step();
    check_eq("t6_cnt_sat", 32'(stall_cnt), 32'hFFFF);
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    check_eq("t6_cnt_flush", 32'(stall_cnt), 32'hFFFF);
    rst = 1'b1;
    #1;
    check_eq("t6_cnt_rst", 32'(stall_cnt), 32'd0);
    step();
    rst = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/riscv_v_elastic_stage.md
Name: riscv_v_elastic_stage

Overview:
Single elastic pipeline stage with valid/ready handshake and a 2-entry skid buffer. It carries the same payload as the existing enable-driven stage, but backpressure flows upstream: the ready signal travels in the opposite direction to the data. Sits between decode/issue and the vector register-file access stages, where a stalled consumer must stop the producer without a combinational ready path across stages. Full throughput of 1 transfer/cycle; 1-cycle latency.

Parameters:
DATA_W, riscv_v_pkg::RISCV_V_RF_ADDR_WIDTH, payload width in bits (must be >= 1)
RST_VAL, '0, value loaded into both data registers on rst and on flush

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  asynchronous, active-high reset
flush  input  1  synchronous flush; empties the stage
in_valid  input  1  upstream payload valid
in_ready  output  1  stage can accept; registered, driven only by state
in_data  input  DATA_W  upstream payload
out_valid  output  1  downstream payload valid
out_ready  input  1  downstream accepts
out_data  output  DATA_W  downstream payload; driven directly from the main register
occupancy  output  2  number of held entries, 0..2

Behaviour:
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Internal registers: main_q, skid_q (both DATA_W wide) and state in {EMPTY, BUSY, FULL}.
- Outputs decode from state only: in_ready = (state != FULL); out_valid = (state != EMPTY); occupancy = 0/1/2 for EMPTY/BUSY/FULL.
- No combinational path from out_ready to in_ready, or from in_* to out_*.
- Reset (async): state = EMPTY; main_q = skid_q = RST_VAL. Resulting outputs: in_ready = 1, out_valid = 0, occupancy = 0, out_data = RST_VAL.
- Priority: rst > flush > normal operation.
- Flush: next state = EMPTY; main_q and skid_q are loaded with RST_VAL. A coincident in_fire or out_fire is discarded. Upstream and downstream must both treat that cycle's transfer as cancelled.
- EMPTY: in_fire -> BUSY, main_q <= in_data. Otherwise stay.
- BUSY:
  - in_fire & out_fire -> BUSY, main_q <= in_data.
  - in_fire & !out_fire -> FULL, skid_q <= in_data.
  - !in_fire & out_fire -> EMPTY.
  - Otherwise hold.
- FULL: in_fire is impossible because in_ready = 0. out_fire -> BUSY, main_q <= skid_q. Otherwise hold.
- Ordering: strict FIFO order is preserved. No payload is duplicated or dropped outside of flush.
- out_data is stable while out_valid & !out_ready, as required by the AXI-style valid/ready rules.
- Illegal state encoding: recovers to EMPTY on the next clock. Assertion fires in simulation.

Optional Feature:
RISCV_V_ELASTIC_STAGE_STALL_CNT_EN
- Defined: adds output stall_cnt [15:0].
  - Increments each cycle out_valid & !out_ready.
  - Saturates at 16'hFFFF.
  - Cleared by rst only; unaffected by flush.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- riscv_v_pkg holds RISCV_V_RF_ADDR_WIDTH (already present).
- riscv_v_pkg gets new typedef enum logic [1:0] riscv_v_elastic_state_e {RISCV_V_ELASTIC_EMPTY, RISCV_V_ELASTIC_BUSY, RISCV_V_ELASTIC_FULL}.
- No sub-module needed. The stall counter stays inline under the macro guard.
- Chaining N instances gives an N-deep elastic pipeline; a wrapper for that is out of scope.

Test Plan:
1. Reset mid-stream: assert rst while state = FULL holding 5'h03, 5'h04 -> same cycle: out_valid = 0, in_ready = 1, occupancy = 0, out_data = RST_VAL (0).
2. Streaming: out_ready = 1, push 5'h01..5'h1F back-to-back -> out_data sequence 01..1F, each one cycle after its in_fire, with no bubbles and in_ready constantly 1.
3. Backpressure:
   - Stimulus: out_ready = 0; push 5'h0A, 5'h0B, 5'h0C.
   - Response: 0A, 0B accepted; in_ready falls after the second accept; occupancy = 2; 0C is held upstream.
   - Then: raise out_ready -> outputs 0A, 0B, 0C in order.
4. Flush with coincident traffic: state BUSY holding 5'h07, then flush = 1 with in_valid = 1, in_data = 5'h08, out_ready = 1 -> next cycle: state EMPTY, out_valid = 0, occupancy = 0; 5'h08 never appears at the output.
5. Randomized in_valid/out_ready (50%) over 10k cycles against a queue scoreboard -> exact order match, occupancy <= 2, out_data stable while stalled.
6. With RISCV_V_ELASTIC_STAGE_STALL_CNT_EN: hold out_ready = 0 with a valid entry for 70000 cycles -> stall_cnt = 16'hFFFF. Then flush -> stall_cnt unchanged. Then rst -> stall_cnt = 0.
